// File: rtl/rr_line_arbiter_pkg.sv
// Shared types for the L1/L2 line arbiter.
//   lc3b_types : physical-memory line and address types used for default widths
//   arb_types  : arbiter state enum and policy constants

package lc3b_types;
    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_pmem_addr;
endpackage

package arb_types;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
endpackage

// File: rtl/rr_line_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Scans the pending vector starting at index ptr, wrapping around, and
// returns the first pending port. With ptr tied to 0 it is a plain
// lowest-index-wins priority encoder.
// Ports:
//   pending : per-port request vector
//   ptr     : index where the scan starts
//   grant   : one-hot winner (zero when nothing is pending)
//   index   : binary winner index (zero when nothing is pending)
//   valid   : at least one port is pending

module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     index,
    output logic                 valid
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        grant   = '0;
        index   = '0;
        valid   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end
            pos_idx = IDX_W'(pos);
            if (!valid && pending[pos_idx]) begin
                valid          = 1'b1;
                grant[pos_idx] = 1'b1;
                index          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/rr_line_arbiter.sv
// rr_line_arbiter: N-port whole-line arbiter between L1 caches and L2.
// One transaction at a time is latched, issued downstream, and completed with
// a one-cycle req_resp pulse to the winning port. Policy is round-robin
// (RR_MODE=ARB_RR) or fixed lowest-index priority (RR_MODE=ARB_FIXED).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_read/req_write         : per-port level requests, held until req_resp
//   req_address/req_wdata      : per-port packed address and write line
//   req_resp                   : one-hot completion pulse
//   req_rdata                  : shared read line, valid with req_resp
//   pmem_read/pmem_write       : downstream command, held for the whole BUSY state
//   pmem_address/pmem_wdata    : downstream address and write line
//   pmem_resp/pmem_rdata       : downstream completion and read line
//   grant_count                : per-port saturating completed-transaction counters

module rr_line_arbiter
    import lc3b_types::*;
    import arb_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = $bits(lc3b_pmem_line),
    parameter int ADDR_WIDTH = $bits(lc3b_pmem_addr),
    parameter int RR_MODE    = ARB_RR,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [LINE_WIDTH-1:0]           req_rdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [LINE_WIDTH-1:0]           pmem_wdata,
    input  logic                            pmem_resp,
    input  logic [LINE_WIDTH-1:0]           pmem_rdata,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  grant_count
);

    localparam int               IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_PORTS-1:0] gnt_onehot;

    logic [NUM_PORTS-1:0] pending;
    logic [IDX_W-1:0]     pick_ptr;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];
    logic [CNT_WIDTH-1:0]  cnt       [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign addr_arr[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
        assign grant_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

    assign pending = req_read | req_write;

    // Fixed priority is the rotate encoder with the scan always starting at 0.
    assign pick_ptr = (RR_MODE == ARB_RR) ? ptr : '0;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .pending (pending),
        .ptr     (pick_ptr),
        .grant   (pick_grant),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt_idx      <= '0;
            gnt_onehot   <= '0;
            req_resp     <= '0;
            req_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx      <= pick_idx;
                        gnt_onehot   <= pick_grant;
                        pmem_address <= addr_arr[pick_idx];
                        pmem_wdata   <= wdata_arr[pick_idx];
                        // A port raising both read and write is served as a write.
                        pmem_write   <= req_write[pick_idx];
                        pmem_read    <= ~req_write[pick_idx];
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        req_rdata  <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        req_resp   <= gnt_onehot;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_resp <= '0;
                    state    <= IDLE;
                    if (RR_MODE == ARB_RR) begin
                        ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    end
                    if (cnt[gnt_idx] != '1) begin
                        cnt[gnt_idx] <= cnt[gnt_idx] + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
